// File: rtl/mem_responder.sv
// Memory-bus responder: byte RAM, GPIO, coherent 32-bit cycle counter and a 4-entry TX FIFO
// behind a single-cycle registered read port.
module mem_responder #(
    parameter int unsigned MABL   = 19,
    parameter int unsigned RAM_AW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [MABL-1:0] ad,
    input  logic            we,
    input  logic [7:0]      wd,
    output logic [7:0]      rd,
    input  logic [7:0]      gpio_in,
    output logic [7:0]      gpio_out,
    output logic            tx_valid,
    output logic [7:0]      tx_data,
    input  logic            tx_ready
);

    localparam int unsigned RAM_BYTES  = 2 ** RAM_AW;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned CYC_W      = 32;
    localparam int unsigned SHD_W      = 24;

    localparam logic [3:0] OFF_GPIO_OUT = 4'h0;
    localparam logic [3:0] OFF_GPIO_IN  = 4'h1;
    localparam logic [3:0] OFF_CNT0     = 4'h4;
    localparam logic [3:0] OFF_CNT1     = 4'h5;
    localparam logic [3:0] OFF_CNT2     = 4'h6;
    localparam logic [3:0] OFF_CNT3     = 4'h7;
    localparam logic [3:0] OFF_TX_DATA  = 4'h8;
    localparam logic [3:0] OFF_TX_STAT  = 4'h9;

    logic [7:0]       ram_q [RAM_BYTES];
    logic [7:0]       fifo_q [FIFO_DEPTH];
    logic [7:0]       fifo_d [FIFO_DEPTH];

    logic [7:0]       rd_q, rd_d;
    logic [7:0]       gpio_out_q, gpio_out_d;
    logic [7:0]       sync1_q, sync2_q;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [SHD_W-1:0] shadow_q, shadow_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_data_q, tx_data_d;

    logic             ram_sel, mmio_sel, ram_we;
    logic [3:0]       off;
    logic             push_req, pop, push_ok, ovf_set, stat_rd;

    assign ram_sel  = (ad[MABL-1:RAM_AW] == '0);
    assign mmio_sel = (&ad[MABL-1:4]) && !ram_sel;
    assign off      = ad[3:0];
    assign ram_we   = rst_n && we && ram_sel;

    always_comb begin
        push_req = we && mmio_sel && (off == OFF_TX_DATA);
        pop      = (count_q != '0) && tx_ready;
        // A full FIFO still takes a push when the head leaves on the same edge.
        push_ok  = push_req && ((count_q < CNT_W'(FIFO_DEPTH)) || pop);
        ovf_set  = push_req && !push_ok;
        stat_rd  = mmio_sel && (off == OFF_TX_STAT);

        fifo_d = fifo_q;
        if (push_ok) begin
            fifo_d[wr_ptr_q] = wd;
        end
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        tx_valid_d = (count_d != '0);
        tx_data_d  = tx_valid_d ? fifo_d[rd_ptr_d] : 8'h00;
        ovf_d      = ovf_set || (ovf_q && !stat_rd);

        cyc_d      = cyc_q + CYC_W'(1);
        shadow_d   = (mmio_sel && (off == OFF_CNT0)) ? cyc_q[CYC_W-1:8] : shadow_q;
        gpio_out_d = (we && mmio_sel && (off == OFF_GPIO_OUT)) ? wd : gpio_out_q;

        rd_d = 8'h00;
        if (ram_sel) begin
            rd_d = ram_q[ad[RAM_AW-1:0]];
        end else if (mmio_sel) begin
            case (off)
                OFF_GPIO_OUT: rd_d = gpio_out_q;
                OFF_GPIO_IN:  rd_d = sync2_q;
                OFF_CNT0:     rd_d = cyc_q[7:0];
                OFF_CNT1:     rd_d = shadow_q[7:0];
                OFF_CNT2:     rd_d = shadow_q[15:8];
                OFF_CNT3:     rd_d = shadow_q[23:16];
                OFF_TX_STAT:  rd_d = {2'b00, count_q, ovf_q, (count_q == '0),
                                      (count_q == CNT_W'(FIFO_DEPTH))};
                default:      rd_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q       <= '0;
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            cyc_q      <= '0;
            shadow_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            rd_q       <= rd_d;
            gpio_out_q <= gpio_out_d;
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
            cyc_q      <= cyc_d;
            shadow_q   <= shadow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Storage arrays carry no reset; count and tx_data_q gate stale contents.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            fifo_q <= fifo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ad[RAM_AW-1:0]] <= wd;
        end
    end

    assign rd       = rd_q;
    assign gpio_out = gpio_out_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised and directed bench for mem_responder against a queue/array reference model.
module tb_mem_responder;

    localparam int unsigned MABL   = 19;
    localparam int unsigned RAM_AW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [MABL-1:0] ad = '0;
    logic            we = 1'b0;
    logic [7:0]      wd = '0;
    logic [7:0]      rd;
    logic [7:0]      gpio_in = '0;
    logic [7:0]      gpio_out;
    logic            tx_valid;
    logic [7:0]      tx_data;
    logic            tx_ready = 1'b0;

    always #5 clk = ~clk;

    mem_responder #(.MABL(MABL), .RAM_AW(RAM_AW)) dut (
        .clk(clk), .rst_n(rst_n), .ad(ad), .we(we), .wd(wd), .rd(rd),
        .gpio_in(gpio_in), .gpio_out(gpio_out),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model state
    logic [7:0]  ram_m [int];
    logic [7:0]  ghist [int];
    logic [7:0]  q [$];
    bit          ovf_m;
    logic [31:0] cyc_m;
    logic [23:0] shadow_m;
    logic [7:0]  gout_m;
    logic [7:0]  rd_m;
    bit          rd_known;
    bit          model_ok = 0;
    int          edge_n = 0;

    localparam logic [MABL-1:0] IDLE = 19'h20000;

    function automatic logic [MABL-1:0] mmio(input logic [3:0] o);
        return {{(MABL-4){1'b1}}, o};
    endfunction

    task automatic model_edge(input logic [MABL-1:0] a, input logic w, input logic [7:0] d,
                              input logic rdy, input logic rs);
        logic [3:0] o;
        bit is_ram, is_mmio, popped, set;
        o       = a[3:0];
        is_ram  = (int'(a) < (1 << RAM_AW));
        is_mmio = !is_ram && (a[MABL-1:4] == {(MABL-4){1'b1}});
        if (!rs) begin
            rd_m = 8'h00; rd_known = 1; gout_m = 8'h00; cyc_m = 0; shadow_m = 0;
            q.delete(); ovf_m = 0;
            ghist[edge_n] = 8'h00; ghist[edge_n-1] = 8'h00;
            model_ok = 1;
            edge_n++;
            return;
        end
        ghist[edge_n] = gpio_in;
        rd_known = 1; rd_m = 8'h00;
        if (is_ram) begin
            if (ram_m.exists(int'(a))) rd_m = ram_m[int'(a)];
            else rd_known = 0;
        end else if (is_mmio) begin
            case (o)
                4'h0: rd_m = gout_m;
                4'h1: if (ghist.exists(edge_n-2)) rd_m = ghist[edge_n-2]; else rd_known = 0;
                4'h4: rd_m = cyc_m[7:0];
                4'h5: rd_m = shadow_m[7:0];
                4'h6: rd_m = shadow_m[15:8];
                4'h7: rd_m = shadow_m[23:16];
                4'h9: rd_m = {2'b00, 3'(q.size()), ovf_m, q.size() == 0, q.size() == 4};
                default: rd_m = 8'h00;
            endcase
        end
        if (w && is_ram) ram_m[int'(a)] = d;
        if (w && is_mmio && o == 4'h0) gout_m = d;
        if (is_mmio && o == 4'h4) shadow_m = cyc_m[31:8];
        popped = (q.size() != 0) && rdy;
        if (popped) void'(q.pop_front());
        set = 0;
        if (w && is_mmio && o == 4'h8) begin
            if (q.size() < 4) q.push_back(d);
            else set = 1;
        end
        if (is_mmio && o == 4'h9) ovf_m = 0;
        if (set) ovf_m = 1;
        cyc_m++;
        edge_n++;
    endtask

    task automatic step(input logic [MABL-1:0] a, input logic w = 1'b0, input logic [7:0] d = 8'h00,
                        input logic rdy = 1'b0, input logic rs = 1'b1);
        ad = a; we = w; wd = d; tx_ready = rdy; rst_n = rs;
        @(posedge clk);
        model_edge(a, w, d, rdy, rs);
        #1;
        if (model_ok) begin
            if (rd_known) check("rd", 32'(rd), 32'(rd_m));
            check("gpio_out", 32'(gpio_out), 32'(gout_m));
            check("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
            check("tx_data", 32'(tx_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
        end
    endtask

    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_cnt;
    logic [7:0]  emitted [$];
    int          first;

    initial begin
        // Reset state
        step(IDLE, 0, 0, 0, 0);
        step(IDLE, 0, 0, 0, 0);
        check("rst_rd", 32'(rd), 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);

        // RAM write then back-to-back reads
        step(19'h100, 1, 8'h11); step(19'h101, 1, 8'h22);
        step(19'h102, 1, 8'h33); step(19'h103, 1, 8'h44);
        step(19'h100); check("ram_100", 32'(rd), 32'h11);
        step(19'h101); check("ram_101", 32'(rd), 32'h22);
        step(19'h102); check("ram_102", 32'(rd), 32'h33);
        step(19'h103); check("ram_103", 32'(rd), 32'h44);
        step(19'h10000, 1, 8'h99); step(19'h10000);
        check("ram_oob", 32'(rd), 32'h0);

        // Counter coherence 10 cycles after reset
        step(IDLE, 0, 0, 0, 0);
        repeat (10) step(IDLE);
        exp_cnt = cyc_m;
        step(mmio(4)); b0 = rd;
        step(mmio(5)); b1 = rd;
        step(mmio(6)); b2 = rd;
        step(mmio(7)); b3 = rd;
        check("cnt_coherent", {b3, b2, b1, b0}, exp_cnt);
        check("cnt_10", exp_cnt, 32'd10);

        // Counter at 0xFF when the low byte is read
        step(IDLE, 0, 0, 0, 0);
        for (int i = 0; i < 300 && cyc_m != 32'hFF; i++) step(IDLE);
        step(mmio(4)); check("cnt_ff_b0", 32'(rd), 32'hFF);
        step(mmio(5)); check("cnt_ff_b1", 32'(rd), 32'h00);
        step(mmio(6)); check("cnt_ff_b2", 32'(rd), 32'h00);
        step(mmio(7)); check("cnt_ff_b3", 32'(rd), 32'h00);

        // FIFO fill, overflow, drain order
        step(IDLE, 0, 0, 0, 0);
        step(mmio(8), 1, 8'hA1); step(mmio(8), 1, 8'hB2);
        step(mmio(8), 1, 8'hC3); step(mmio(8), 1, 8'hD4);
        step(mmio(9)); check("stat_full", 32'(rd), 32'h21);
        step(mmio(8), 1, 8'hE5);
        step(mmio(9)); check("stat_ovf", 32'(rd), 32'h25);
        step(mmio(9)); check("stat_ovf_clr", 32'(rd), 32'h21);
        emitted.delete();
        for (int i = 0; i < 10 && tx_valid; i++) begin
            emitted.push_back(tx_data);
            step(IDLE, 0, 0, 1);
        end
        check("drain_n", 32'(emitted.size()), 32'd4);
        if (emitted.size() == 4) begin
            check("drain0", 32'(emitted[0]), 32'hA1);
            check("drain1", 32'(emitted[1]), 32'hB2);
            check("drain2", 32'(emitted[2]), 32'hC3);
            check("drain3", 32'(emitted[3]), 32'hD4);
        end
        step(mmio(9)); check("stat_empty", 32'(rd), 32'h02);

        // Full with simultaneous push and pop
        step(mmio(8), 1, 8'h11); step(mmio(8), 1, 8'h22);
        step(mmio(8), 1, 8'h33); step(mmio(8), 1, 8'h44);
        step(mmio(8), 1, 8'h55, 1);
        step(mmio(9)); check("full_pop_stat", 32'(rd), 32'h21);
        emitted.delete();
        for (int i = 0; i < 10 && tx_valid; i++) begin
            emitted.push_back(tx_data);
            step(IDLE, 0, 0, 1);
        end
        check("full_pop_n", 32'(emitted.size()), 32'd4);
        if (emitted.size() != 0) check("full_pop_last", 32'(emitted[emitted.size()-1]), 32'h55);

        // GPIO
        step(mmio(0), 1, 8'hA5); check("gpio_out_a5", 32'(gpio_out), 32'hA5);
        gpio_in = 8'h3C;
        first = -1;
        for (int i = 1; i <= 6; i++) begin
            step(mmio(1));
            if (first < 0 && rd == 8'h3C) first = i;
        end
        check("gpio_in_lat", 32'(first), 32'd3);

        // Reset during a push with two entries queued
        step(19'h200, 1, 8'h77);
        step(mmio(0), 1, 8'h5A);
        step(mmio(8), 1, 8'h01); step(mmio(8), 1, 8'h02);
        step(mmio(8), 1, 8'h03, 0, 0);
        check("rst_mid_valid", 32'(tx_valid), 32'h0);
        check("rst_mid_rd", 32'(rd), 32'h0);
        check("rst_mid_gpio", 32'(gpio_out), 32'h0);
        step(mmio(4)); check("rst_mid_cnt", 32'(rd), 32'h0);
        step(mmio(9)); check("rst_mid_stat", 32'(rd), 32'h02);
        step(19'h200); check("rst_mid_ram", 32'(rd), 32'h77);

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            int unsigned r;
            logic [MABL-1:0] a;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: a = MABL'($urandom_range(0, 15));
                3:       a = MABL'($urandom_range(0, 65535));
                4, 5, 6, 7: a = mmio(4'($urandom_range(0, 15)));
                8:       a = MABL'($urandom_range(32'h10000, 32'h7FFEF));
                default: a = mmio(4'h8);
            endcase
            if ($urandom_range(0, 7) == 0) gpio_in = 8'($urandom);
            step(a, 1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 149) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
